mem_read_arbiter: RTL
=====================

// Module: mem_read_arbiter
// PURPOSE
//   Two-requester arbiter for the shared read port of video/audio memory.
//   Port A (pri_*, VGA bitgen) has fixed priority. Port B (sec_*, audio mixer) is serviced in idle slots.
//   Port B is also guaranteed a forced slot after MAX_WAIT consecutive denied cycles, so it cannot starve.
//   Issued reads are tagged through a pipeline matching memory read latency; returned data is steered to its owner.
// PARAMETERS
//   ADDR_W       18  memory word address width
//   DATA_W       16  memory read data width
//   MEM_LATENCY  1   edges from address sample to valid mem_rd_data (>=1)
//   MAX_WAIT     4   consecutive denied cycles of sec_req before a forced grant (>=1)
// PORTS
//   clk           in   1       system clock, all state on rising edge
//   reset         in   1       asynchronous, active-high reset
//   pri_req       in   1       priority read request
//   pri_addr      in   ADDR_W  priority read address, valid while pri_req
//   pri_gnt       out  1       priority request accepted this cycle (comb.)
//   pri_rd_valid  out  1       one-cycle pulse: pri_rd_data updated
//   pri_rd_data   out  DATA_W  last data returned to priority port (registered)
//   sec_req       in   1       secondary read request, held until sec_gnt
//   sec_addr      in   ADDR_W  secondary read address, stable while sec_req
//   sec_gnt       out  1       secondary request accepted this cycle (comb.)
//   sec_rd_valid  out  1       one-cycle pulse: sec_rd_data updated
//   sec_rd_data   out  DATA_W  last data returned to secondary port (registered)
//   mem_addr      out  ADDR_W  address to memory read port (comb.)
//   mem_rd_en     out  1       pri_gnt | sec_gnt
//   mem_rd_data   in   DATA_W  memory read data, valid MEM_LATENCY edges after issue
// BEHAVIOUR
//   Reset: state=NORMAL, wait_cnt=0, tag pipe cleared.
//     *_rd_valid=0 and *_rd_data=0 during and after reset; gnt outputs follow the comb. rules below.
//   Accept: a read is issued at a rising edge where a port's req & gnt are both 1.
//     At most one gnt is high per cycle.
//   mem_addr = sec_gnt ? sec_addr : pri_addr.
//   FSM NORMAL: pri_gnt=pri_req; sec_gnt=sec_req & ~pri_req.
//     wait_cnt: +1 on edges with sec_req & ~sec_gnt; clears on sec_gnt or ~sec_req.
//     Go to FORCE_SEC when a denied edge brings wait_cnt to MAX_WAIT.
//   FSM FORCE_SEC: sec_gnt=sec_req; pri_gnt=pri_req & ~sec_req.
//     Always return to NORMAL next edge; wait_cnt clears.
//     If sec_req has dropped (protocol violation), the slot goes to pri and no error is flagged.
//   Counter width $clog2(MAX_WAIT+1); it never exceeds MAX_WAIT and does not wrap.
//   Tag pipe: MEM_LATENCY stages of {valid, owner}.
//     Stage 1 loads {mem_rd_en, sec_gnt} each edge; entries shift one stage per edge.
//   Return: on the edge where the last stage is valid, mem_rd_data is captured into the owner's *_rd_data.
//     The owner's *_rd_valid pulses high in the following cycle.
//     Total: rd_valid is high exactly MEM_LATENCY+1 cycles after the accepting edge; single cycle.
//     The non-owner's rd_data is unchanged.
//   Throughput: one read per cycle; back-to-back grants to either port are allowed.
//     Returns keep issue order.
//   Simultaneous pri_req & sec_req in NORMAL with wait_cnt<MAX_WAIT-1: pri wins, sec counts.
//   Reset mid-operation: in-flight reads are discarded; no rd_valid appears for them after reset release.
// TESTING
//   Memory model: mem_rd_data = {addr[15:0]} after MEM_LATENCY edges; run MEM_LATENCY=1 and 3.
//   1. pri_req=1 constant, pri_addr 0x00010..0x0001F, sec_req=0 -> pri_gnt every cycle.
//      pri_rd_valid continuous from issue+MEM_LATENCY+1; data 0x0010..0x001F in order; sec_rd_valid never high.
//   2. sec_req=1, sec_addr=0x20004, pri_req=0 -> sec_gnt same cycle, mem_addr=0x20004.
//      sec_rd_data=0x0004 with a one-cycle sec_rd_valid MEM_LATENCY+1 cycles later.
//   3. pri_req=1 and sec_req=1 held, MAX_WAIT=4 -> sec denied 4 cycles, granted on the 5th with pri_gnt=0.
//      Pattern repeats every 5 cycles; never two gnts in one cycle.
//   4. Interleave pri 0x00100 and sec 0x00200 grants on alternate cycles.
//      -> pri_rd_data=0x0100 and sec_rd_data=0x0200 each hold until their own next valid; no cross-delivery.
//   5. Assert reset while 2 reads are in flight (MEM_LATENCY=3).
//      -> no rd_valid pulses; rd_data=0; after release FSM=NORMAL and the first new grant returns correctly.
//   6. Both req high, sec_req dropped after 3 denials, re-raised.
//      -> wait_cnt=0; the forced grant needs 4 fresh denials; pri keeps every slot meanwhile.

Source files
------------

// File: rtl/mem_read_arbiter.sv
// Shared read-port arbiter for video/audio memory.
// The primary port (VGA bitgen) has fixed priority. The secondary port (audio
// mixer) uses idle slots and is forced through after MAX_WAIT consecutive
// denials. Issued reads carry an owner tag down a pipeline that matches memory
// latency, so returned data is steered back to the port that issued it.
module mem_read_arbiter #(
  parameter int ADDR_W      = 18,
  parameter int DATA_W      = 16,
  parameter int MEM_LATENCY = 1,
  parameter int MAX_WAIT    = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pri_req,
  input  logic [ADDR_W-1:0] pri_addr,
  output logic              pri_gnt,
  output logic              pri_rd_valid,
  output logic [DATA_W-1:0] pri_rd_data,
  input  logic              sec_req,
  input  logic [ADDR_W-1:0] sec_addr,
  output logic              sec_gnt,
  output logic              sec_rd_valid,
  output logic [DATA_W-1:0] sec_rd_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [DATA_W-1:0] mem_rd_data
);

  localparam int          CNT_W     = $clog2(MAX_WAIT + 1);
  localparam int unsigned LAT       = MEM_LATENCY;
  localparam logic [CNT_W-1:0] WAIT_FULL = CNT_W'(MAX_WAIT);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

  typedef enum logic {
    NORMAL,
    FORCE_SEC
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_cnt_next;

  // Per-stage owner tags: valid marks an issued read, sec marks the owner.
  logic [MEM_LATENCY-1:0] tag_valid;
  logic [MEM_LATENCY-1:0] tag_sec;

  assign mem_rd_en = pri_gnt | sec_gnt;
  assign mem_addr  = sec_gnt ? sec_addr : pri_addr;

  // Arbitration state and starvation counter register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= NORMAL;
      wait_cnt <= '0;
    end else begin
      state    <= state_next;
      wait_cnt <= wait_cnt_next;
    end
  end

  // Grant decode, next state and starvation counter update.
  always_comb begin
    state_next    = state;
    wait_cnt_next = '0;
    pri_gnt       = 1'b0;
    sec_gnt       = 1'b0;
    case (state)
      NORMAL: begin
        pri_gnt = pri_req;
        sec_gnt = sec_req & ~pri_req;
        // Only a denied, still-pending secondary request advances the count;
        // a grant or a dropped request starts the count over.
        if (sec_req && !sec_gnt) begin
          if (wait_cnt >= WAIT_LAST) begin
            wait_cnt_next = WAIT_FULL;
            state_next    = FORCE_SEC;
          end else begin
            wait_cnt_next = wait_cnt + CNT_W'(1);
          end
        end
      end
      FORCE_SEC: begin
        // The forced slot falls back to the primary port if the secondary
        // request was withdrawn in the meantime.
        sec_gnt    = sec_req;
        pri_gnt    = pri_req & ~sec_req;
        state_next = NORMAL;
      end
      default: state_next = NORMAL;
    endcase
  end

  // Owner tag pipeline, one stage per cycle of memory latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tag_valid <= '0;
      tag_sec   <= '0;
    end else begin
      tag_valid[0] <= mem_rd_en;
      tag_sec[0]   <= sec_gnt;
      for (int unsigned i = 1; i < LAT; i++) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_sec[i]   <= tag_sec[i-1];
      end
    end
  end

  // Capture returning data into the owning port and pulse its valid.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pri_rd_valid <= 1'b0;
      sec_rd_valid <= 1'b0;
      pri_rd_data  <= '0;
      sec_rd_data  <= '0;
    end else begin
      pri_rd_valid <= tag_valid[LAT-1] & ~tag_sec[LAT-1];
      sec_rd_valid <= tag_valid[LAT-1] &  tag_sec[LAT-1];
      if (tag_valid[LAT-1]) begin
        if (tag_sec[LAT-1]) begin
          sec_rd_data <= mem_rd_data;
        end else begin
          pri_rd_data <= mem_rd_data;
        end
      end
    end
  end

endmodule
